// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker.
//   chk_state_e : checker lock state (HUNT while searching, LOCKED while tracking)
//   tap_of()    : second feedback tap for each supported polynomial order
//                 (7, 15, 23, 31); returns 0 for an unsupported order.
package prbs_pkg;

  typedef enum logic {
    HUNT,
    LOCKED
  } chk_state_e;

  // Feedback taps: x^7+x^6+1, x^15+x^14+1, x^23+x^18+1, x^31+x^28+1.
  function automatic int unsigned tap_of(input int unsigned order);
    case (order)
      7:       return 6;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational Fibonacci LFSR advance by DataW bits.
// Ports:
//   state      in   Order  current LFSR state (bit 0 = newest bit)
//   data       out  DataW  generated bits, bit 0 earliest in time
//   next_state out  Order  state after DataW shifts
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int unsigned DataW = 32,
  parameter int unsigned Order = 31
) (
  input  logic [Order-1:0] state,
  output logic [DataW-1:0] data,
  output logic [Order-1:0] next_state
);

  localparam int unsigned Tap = tap_of(Order);

  always_comb begin
    logic [Order-1:0] s;
    logic             fb;
    s    = state;
    data = '0;
    for (int i = 0; i < DataW; i++) begin
      fb      = s[Order-1] ^ s[Tap-1];
      data[i] = fb;
      s       = {s[Order-2:0], fb};
    end
    next_state = s;
  end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS pattern generator (valid/ready source) and self-locking checker with a
// saturating bit-error counter. Both halves share one clock and reset.
// Optional build macro: PRBS_GEN_CHK_ERR_INJ_EN adds input inject_err, which
// inverts bit 0 of the next beat loaded into the generator output.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   enable                   generator run request
//   gen_tdata/tvalid/tready  generated stream
//   chk_tdata/tvalid/tready  received stream (tready is 1 once out of reset)
//   clr_cnt                  synchronous clear of err_cnt
//   locked                   checker is in LOCKED
//   err_cnt                  saturating count of mismatched bits while LOCKED
//   bit_err                  pulse: last accepted beat had errors while LOCKED
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int unsigned             P_DATA_W     = 32,
  parameter int unsigned             P_PRBS_ORDER = 31,
  parameter int unsigned             P_LOCK_CNT   = 4,
  parameter int unsigned             P_ERR_CNT_W  = 16,
  parameter logic [P_PRBS_ORDER-1:0] P_SEED       = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
`ifdef PRBS_GEN_CHK_ERR_INJ_EN
  input  logic                   inject_err,
`endif
  output logic [P_DATA_W-1:0]    gen_tdata,
  output logic                   gen_tvalid,
  input  logic                   gen_tready,
  input  logic [P_DATA_W-1:0]    chk_tdata,
  input  logic                   chk_tvalid,
  output logic                   chk_tready,
  input  logic                   clr_cnt,
  output logic                   locked,
  output logic [P_ERR_CNT_W-1:0] err_cnt,
  output logic                   bit_err
);

  localparam int unsigned CntW = $clog2(P_LOCK_CNT + 1);
  localparam int unsigned PcW  = $clog2(P_DATA_W + 1);
  localparam int unsigned SumW = ((P_ERR_CNT_W > PcW) ? P_ERR_CNT_W : PcW) + 1;
  localparam logic [P_ERR_CNT_W-1:0] ErrMax = '1;

  // ---------------- Generator ----------------
  logic [P_PRBS_ORDER-1:0] gen_lfsr_q, gen_lfsr_d, gen_lfsr_nxt;
  logic [P_DATA_W-1:0]     gen_data_q, gen_data_d, gen_beat, inj_mask;
  logic                    gen_valid_q, gen_valid_d, gen_load;

  prbs_lfsr_step #(
    .DataW(P_DATA_W),
    .Order(P_PRBS_ORDER)
  ) u_gen_step (
    .state     (gen_lfsr_q),
    .data      (gen_beat),
    .next_state(gen_lfsr_nxt)
  );

  // A new beat enters the output register only when it is empty or being drained.
  assign gen_load = enable && (!gen_valid_q || gen_tready);

`ifdef PRBS_GEN_CHK_ERR_INJ_EN
  logic inj_armed_q, inj_armed_d;
  // Pulses while armed are absorbed; the flag clears when it corrupts a beat.
  assign inj_armed_d = inj_armed_q ? !gen_load : inject_err;
  assign inj_mask    = {{(P_DATA_W-1){1'b0}}, inj_armed_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inj_armed_q <= 1'b0;
    else        inj_armed_q <= inj_armed_d;
  end
`else
  assign inj_mask = '0;
`endif

  always_comb begin
    gen_valid_d = gen_valid_q;
    gen_data_d  = gen_data_q;
    gen_lfsr_d  = gen_lfsr_q;
    if (!gen_valid_q || gen_tready) gen_valid_d = enable;
    if (gen_load) begin
      gen_data_d = gen_beat ^ inj_mask;
      gen_lfsr_d = gen_lfsr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_lfsr_q  <= P_SEED;
      gen_data_q  <= '0;
      gen_valid_q <= 1'b0;
    end else begin
      gen_lfsr_q  <= gen_lfsr_d;
      gen_data_q  <= gen_data_d;
      gen_valid_q <= gen_valid_d;
    end
  end

  assign gen_tdata  = gen_data_q;
  assign gen_tvalid = gen_valid_q;

  // ---------------- Checker ----------------
  chk_state_e              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d, bad_q, bad_d;
  logic [P_PRBS_ORDER-1:0] prev_q, prev_d, chk_lfsr_q, chk_lfsr_d;
  logic [P_PRBS_ORDER-1:0] beat_state, step_in, chk_nxt;
  logic [P_DATA_W-1:0]     chk_pred, diff;
  logic [PcW-1:0]          n_err, err_add;
  logic [SumW-1:0]         err_sum;
  logic [P_ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                    bit_err_q, bit_err_d, ready_q, beat_bad;

  // Last ORDER bits of the beat as an LFSR state: newest bit lands in bit 0.
  always_comb begin
    beat_state = '0;
    for (int k = 0; k < P_PRBS_ORDER; k++) beat_state[k] = chk_tdata[P_DATA_W-1-k];
  end

  assign step_in = (state_q == LOCKED) ? chk_lfsr_q : prev_q;

  prbs_lfsr_step #(
    .DataW(P_DATA_W),
    .Order(P_PRBS_ORDER)
  ) u_chk_step (
    .state     (step_in),
    .data      (chk_pred),
    .next_state(chk_nxt)
  );

  always_comb begin
    diff  = chk_tdata ^ chk_pred;
    n_err = '0;
    for (int i = 0; i < P_DATA_W; i++) n_err = n_err + PcW'(diff[i]);
  end

  // A zero prediction state would let all-zero data lock, so treat it as a miss.
  assign beat_bad = (diff != '0) || (step_in == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    prev_d     = prev_q;
    chk_lfsr_d = chk_lfsr_q;
    bit_err_d  = 1'b0;
    err_add    = '0;
    if (chk_tvalid) begin
      prev_d = beat_state;
      unique case (state_q)
        HUNT: begin
          if (beat_bad) begin
            cnt_d = '0;
          end else if (cnt_q == CntW'(P_LOCK_CNT - 1)) begin
            state_d    = LOCKED;
            cnt_d      = '0;
            bad_d      = '0;
            chk_lfsr_d = beat_state;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          chk_lfsr_d = chk_nxt;
          bit_err_d  = beat_bad;
          err_add    = n_err;
          if (!beat_bad) begin
            bad_d = '0;
          end else if (bad_q == CntW'(P_LOCK_CNT - 1)) begin
            state_d = HUNT;
            cnt_d   = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    err_sum   = SumW'(err_cnt_q) + SumW'(err_add);
    err_cnt_d = (err_sum > SumW'(ErrMax)) ? ErrMax : err_sum[P_ERR_CNT_W-1:0];
    if (clr_cnt) err_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      bad_q      <= '0;
      prev_q     <= '0;
      chk_lfsr_q <= '0;
      err_cnt_q  <= '0;
      bit_err_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      prev_q     <= prev_d;
      chk_lfsr_q <= chk_lfsr_d;
      err_cnt_q  <= err_cnt_d;
      bit_err_q  <= bit_err_d;
      ready_q    <= 1'b1;
    end
  end

  assign chk_tready = ready_q;
  assign locked     = (state_q == LOCKED);
  assign err_cnt    = err_cnt_q;
  assign bit_err    = bit_err_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Loopback bench for prbs_gen_chk: generator beats are scored against a
// bit-serial model through a queue; checker behaviour is driven from a table
// of corruption masks plus hand-written lock, saturation and reset sequences.
module tb_prbs_gen_chk;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, gen_tready = 1'b0;
  logic        clr_cnt = 1'b0, clr4 = 1'b0, inject_err = 1'b0;
  logic [31:0] mask = '0, mask4 = '0;
  logic [31:0] gen_tdata, gen_tdata4;
  logic        gen_tvalid, gen_tvalid4, chk_tready, chk_tready4;
  logic        locked, locked4, bit_err, bit_err4;
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt4;
  logic        chk_tvalid;
  logic [31:0] chk_tdata, chk_tdata4;

  assign chk_tvalid = gen_tvalid && gen_tready;
  assign chk_tdata  = gen_tdata ^ mask;
  assign chk_tdata4 = gen_tdata ^ mask4;

  always #5 clk = ~clk;

  prbs_gen_chk #(
    .P_DATA_W(32), .P_PRBS_ORDER(31), .P_LOCK_CNT(4), .P_ERR_CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef PRBS_GEN_CHK_ERR_INJ_EN
    .inject_err(inject_err),
`endif
    .gen_tdata(gen_tdata), .gen_tvalid(gen_tvalid), .gen_tready(gen_tready),
    .chk_tdata(chk_tdata), .chk_tvalid(chk_tvalid), .chk_tready(chk_tready),
    .clr_cnt(clr_cnt), .locked(locked), .err_cnt(err_cnt), .bit_err(bit_err)
  );

  // Narrow-counter checker watching the same stream; its own generator idles.
  prbs_gen_chk #(
    .P_DATA_W(32), .P_PRBS_ORDER(31), .P_LOCK_CNT(4), .P_ERR_CNT_W(4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(1'b0),
`ifdef PRBS_GEN_CHK_ERR_INJ_EN
    .inject_err(1'b0),
`endif
    .gen_tdata(gen_tdata4), .gen_tvalid(gen_tvalid4), .gen_tready(1'b1),
    .chk_tdata(chk_tdata4), .chk_tvalid(chk_tvalid), .chk_tready(chk_tready4),
    .clr_cnt(clr4), .locked(locked4), .err_cnt(err_cnt4), .bit_err(bit_err4)
  );

  int n_vec = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference: x^31+x^28+1, output bit = feedback, bit 0 earliest.
  logic [30:0] m_state;
  task automatic model_beat(output logic [31:0] b);
    logic fb;
    for (int i = 0; i < 32; i++) begin
      fb      = m_state[30] ^ m_state[27];
      b[i]    = fb;
      m_state = {m_state[29:0], fb};
    end
  endtask

  logic [31:0] exp_q[$];

  // Advance one clock; inputs change 2 units after the edge, then the
  // scoreboard is topped up with the next expected generator beats.
  task automatic tick();
    logic [31:0] b;
    @(posedge clk);
    #2;
    while (exp_q.size() < 4) begin
      model_beat(b);
      exp_q.push_back(b);
    end
  endtask

  // Output monitor on the falling edge.
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  bit          bit_err_seen = 1'b0;
  int          acc_cnt = 0;
  int          inj_tol = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (bit_err) bit_err_seen = 1'b1;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(gen_tvalid), 64'd1);
        check("stall_data", 64'(gen_tdata), 64'(stall_data));
      end
      if (gen_tvalid && gen_tready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL gen_beat: got 0x%0h, expected nothing queued", gen_tdata);
        end else begin
          e = exp_q.pop_front();
          if (inj_tol > 0 && gen_tdata == (e ^ 32'h1)) begin
            inj_tol--;
            n_vec++;
          end else begin
            check("gen_beat", 64'(gen_tdata), 64'(e));
          end
        end
      end
      stall_prev = gen_tvalid && !gen_tready;
      stall_data = gen_tdata;
    end
  end

  typedef struct {
    logic [31:0] mask;
    int          beats;
    int          exp_err;
    logic        exp_locked;
    logic        exp_biterr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{32'h0000_0000, 20, 0,   1'b1, 1'b0};
    vecs[1] = '{32'h0000_0001, 1,  1,   1'b1, 1'b1};
    vecs[2] = '{32'h0000_0000, 4,  0,   1'b1, 1'b0};
    vecs[3] = '{32'h8000_0001, 3,  6,   1'b1, 1'b1};
    vecs[4] = '{32'h0000_0000, 2,  0,   1'b1, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 4,  128, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0000, 5,  0,   1'b1, 1'b0};
    vecs[7] = '{32'h0000_0000, 10, 0,   1'b1, 1'b0};

    // Reset values while rst_n held low.
    #3;
    check("rst_tvalid", 64'(gen_tvalid), 64'd0);
    check("rst_tdata", 64'(gen_tdata), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_bit_err", 64'(bit_err), 64'd0);
    check("rst_chk_tready", 64'(chk_tready), 64'd0);
    m_state = '1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("chk_tready_up", 64'(chk_tready), 64'd1);

    // Lock latency: first beat has no history, then four clean beats.
    enable     = 1'b1;
    gen_tready = 1'b1;
    acc_cnt    = 0;
    for (int i = 0; i < 20 && !locked; i++) tick();
    check("lock_beats", 64'(acc_cnt), 64'd5);
    check("lock_up", 64'(locked), 64'd1);

    // Long clean loopback.
    bit_err_seen = 1'b0;
    repeat (10000) tick();
    check("long_err_cnt", 64'(err_cnt), 64'd0);
    check("long_bit_err", 64'(bit_err_seen), 64'd0);
    check("long_locked", 64'(locked), 64'd1);

    // Random back-pressure and enable gaps.
    repeat (2000) begin
      gen_tready = 1'($urandom_range(0, 1));
      enable     = ($urandom_range(0, 9) != 0);
      tick();
    end
    gen_tready = 1'b1;
    enable     = 1'b1;
    repeat (3) tick();
    check("rand_locked", 64'(locked), 64'd1);
    check("rand_err_cnt", 64'(err_cnt), 64'd0);

    // Corruption table.
    for (int v = 0; v < 8; v++) begin
      base         = int'(err_cnt);
      bit_err_seen = 1'b0;
      for (int b = 0; b < vecs[v].beats; b++) begin
        mask = vecs[v].mask;
        tick();
      end
      mask = '0;
      tick();
      check($sformatf("vec%0d_err", v), 64'(int'(err_cnt) - base), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_locked", v), 64'(locked), 64'(vecs[v].exp_locked));
      check($sformatf("vec%0d_bit_err", v), 64'(bit_err_seen), 64'(vecs[v].exp_biterr));
    end

    // Saturation on the 4-bit counter: 7+7+6 = 20 errored bits.
    check("sat_locked", 64'(locked4), 64'd1);
    mask4 = 32'h0000_007F; tick();
    mask4 = 32'h7F00_0000; tick();
    mask4 = 32'h0000_3F00; tick();
    mask4 = '0;            tick();
    check("sat_value", 64'(err_cnt4), 64'd15);
    check("sat_still_locked", 64'(locked4), 64'd1);
    tick();
    check("sat_held", 64'(err_cnt4), 64'd15);
    clr4 = 1'b1; tick();
    clr4 = 1'b0;
    check("clr_to_zero", 64'(err_cnt4), 64'd0);
    clr4 = 1'b1; mask4 = 32'h0000_0001; tick();
    clr4 = 1'b0; mask4 = '0;            tick();
    check("clr_wins", 64'(err_cnt4), 64'd0);
    mask4 = 32'h0000_0001; tick();
    mask4 = '0;            tick();
    check("count_after_clr", 64'(err_cnt4), 64'd1);

`ifdef PRBS_GEN_CHK_ERR_INJ_EN
    // Two back-to-back pulses cost one error; then a single pulse.
    base = int'(err_cnt); bit_err_seen = 1'b0; inj_tol = 1;
    inject_err = 1'b1; tick();
    inject_err = 1'b1; tick();
    inject_err = 1'b0;
    repeat (6) tick();
    check("inj2_err", 64'(int'(err_cnt) - base), 64'd1);
    check("inj2_bit_err", 64'(bit_err_seen), 64'd1);
    check("inj2_flipped", 64'(inj_tol), 64'd0);
    base = int'(err_cnt); bit_err_seen = 1'b0; inj_tol = 1;
    inject_err = 1'b1; tick();
    inject_err = 1'b0;
    repeat (6) tick();
    check("inj1_err", 64'(int'(err_cnt) - base), 64'd1);
    check("inj1_bit_err", 64'(bit_err_seen), 64'd1);
    check("inj1_locked", 64'(locked), 64'd1);
`endif

    // Asynchronous reset pulse away from the clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(gen_tvalid), 64'd0);
    check("mid_rst_tdata", 64'(gen_tdata), 64'd0);
    check("mid_rst_locked", 64'(locked), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    check("mid_rst_bit_err", 64'(bit_err), 64'd0);
    check("mid_rst_chk_tready", 64'(chk_tready), 64'd0);
    exp_q.delete();
    m_state = '1;
    #9;
    rst_n = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 30 && !locked; i++) tick();
    check("relock_after_rst", 64'(locked), 64'd1);
    check("relock_beats", 64'(acc_cnt), 64'd5);
    repeat (5) tick();
    check("post_rst_err_cnt", 64'(err_cnt), 64'd0);
    check("idle_gen_tvalid", 64'(gen_tvalid4), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
